// File: rtl/baseball_pkg.sv
// Shared types and constants for the two-player number-baseball game sequencer.
// Holds the FSM state encoding, winner codes and the digit acceptance rule.
package baseball_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] MAX_DIGIT = 4'd9;
    localparam int MAX_WORD_W = 12;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP_P1 = 3'd1,
        ST_SETUP_P2 = 3'd2,
        ST_TURN_P1  = 3'd3,
        ST_JUDGE_P1 = 3'd4,
        ST_TURN_P2  = 3'd5,
        ST_JUDGE_P2 = 3'd6,
        ST_OVER     = 3'd7
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    // The word is right-aligned: the idx most recently entered digits sit in the low nibbles.
    function automatic logic digit_ok(input logic [MAX_WORD_W-1:0] word,
                                      input logic [1:0]            idx,
                                      input logic [DIGIT_W-1:0]    digit);
        logic ok;
        ok = (digit <= MAX_DIGIT);
        for (int k = 0; k < 3; k++) begin
            if ((k < int'(idx)) && (word[k*DIGIT_W +: DIGIT_W] == digit)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/digit_entry.sv
// Shared digit shift register: accepts BCD digits with range/duplicate rejection,
// counts entered digits and flags the accept that completes the word.
module digit_entry
    import baseball_pkg::*;
#(
    parameter int NUM_DIGITS = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_accept,
    input  logic [DIGIT_W-1:0]              i_digit,
    input  logic                            i_clear,
    output logic [NUM_DIGITS*DIGIT_W-1:0]   o_word,
    output logic [1:0]                      o_idx,
    output logic                            o_full,
    output logic                            o_invalid
);

    localparam int W = NUM_DIGITS * DIGIT_W;

    logic [W-1:0] r_word;
    logic [1:0]   r_idx;
    logic         r_invalid;
    logic         w_ok;

    assign w_ok = digit_ok(MAX_WORD_W'(r_word), r_idx, i_digit);

    // Combinational so the controller can change phase on the same edge the last digit lands.
    assign o_full = i_accept && w_ok && (r_idx == 2'(NUM_DIGITS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word    <= '0;
            r_idx     <= '0;
            r_invalid <= 1'b0;
        end else begin
            r_invalid <= i_accept && !w_ok;
            if (i_clear) begin
                r_word <= '0;
                r_idx  <= '0;
            end else if (i_accept && w_ok) begin
                r_word <= {r_word[W-DIGIT_W-1:0], i_digit};
                r_idx  <= r_idx + 2'd1;
            end
        end
    end

    assign o_word    = r_word;
    assign o_idx     = r_idx;
    assign o_invalid = r_invalid;

endmodule

// File: rtl/baseball_turn_ctrl.sv
// Game sequencer: collects both secrets, alternates guessing turns, hands each guess
// to the external judge over a level req / pulse ack handshake and resolves the winner.
module baseball_turn_ctrl
    import baseball_pkg::*;
#(
    parameter int NUM_DIGITS = 3,
    parameter int MAX_ROUNDS = 9
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            i_start,
    input  logic [3:0]                      i_digit_in,
    input  logic                            i_enter_p1,
    input  logic                            i_enter_p2,
    input  logic                            i_judge_ack,
    input  logic [1:0]                      i_judge_strike,
    input  logic [1:0]                      i_judge_ball,
    output logic                            o_guess_mode,
    output logic                            o_active_player,
    output logic [1:0]                      o_digit_idx,
    output logic [4*NUM_DIGITS-1:0]         o_secret_p1,
    output logic [4*NUM_DIGITS-1:0]         o_secret_p2,
    output logic [4*NUM_DIGITS-1:0]         o_guess_word,
    output logic                            o_judge_req,
    output logic [4*NUM_DIGITS-1:0]         o_target_word,
    output logic [1:0]                      o_last_strike,
    output logic [1:0]                      o_last_ball,
    output logic [3:0]                      o_round_cnt,
    output logic                            o_invalid_entry,
    output logic                            o_game_over,
    output logic [1:0]                      o_winner,
    output logic [2:0]                      o_state
);

    localparam int W = 4 * NUM_DIGITS;

    state_t       r_state;
    logic [W-1:0] r_secret_p1;
    logic [W-1:0] r_secret_p2;
    logic [W-1:0] r_guess_word;
    logic [W-1:0] r_target_word;
    logic         r_guess_mode;
    logic         r_active_player;
    logic         r_judge_req;
    logic [1:0]   r_last_strike;
    logic [1:0]   r_last_ball;
    logic [3:0]   r_round_cnt;
    logic         r_game_over;
    logic [1:0]   r_winner;
    logic         r_p1_hit;

    logic         w_accept;
    logic         w_ok;
    logic         w_full;
    logic         w_start;
    logic         w_clear;
    logic         w_p2_hit;
    logic [W-1:0] w_word;
    logic [W-1:0] w_next_word;
    logic [1:0]   w_idx;
    logic         w_invalid;

    // Only the player who owns the current phase may enter digits.
    always_comb begin
        w_accept = 1'b0;
        case (r_state)
            ST_SETUP_P1, ST_TURN_P1: w_accept = i_enter_p1;
            ST_SETUP_P2, ST_TURN_P2: w_accept = i_enter_p2;
            default:                 w_accept = 1'b0;
        endcase
    end

    assign w_start     = i_start && ((r_state == ST_IDLE) || (r_state == ST_OVER));
    assign w_clear     = w_start || w_full;
    assign w_ok        = digit_ok(MAX_WORD_W'(w_word), w_idx, i_digit_in);
    assign w_next_word = {w_word[W-DIGIT_W-1:0], i_digit_in};
    assign w_p2_hit    = (i_judge_strike == 2'(NUM_DIGITS));

    digit_entry #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_digit_entry (
        .clk        (clk),
        .rst        (rst),
        .i_accept   (w_accept),
        .i_digit    (i_digit_in),
        .i_clear    (w_clear),
        .o_word     (w_word),
        .o_idx      (w_idx),
        .o_full     (w_full),
        .o_invalid  (w_invalid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_secret_p1     <= '0;
            r_secret_p2     <= '0;
            r_guess_word    <= '0;
            r_target_word   <= '0;
            r_guess_mode    <= 1'b0;
            r_active_player <= 1'b0;
            r_judge_req     <= 1'b0;
            r_last_strike   <= '0;
            r_last_ball     <= '0;
            r_round_cnt     <= '0;
            r_game_over     <= 1'b0;
            r_winner        <= WIN_NONE;
            r_p1_hit        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_OVER: begin
                    if (i_start) begin
                        r_state         <= ST_SETUP_P1;
                        r_secret_p1     <= '0;
                        r_secret_p2     <= '0;
                        r_guess_word    <= '0;
                        r_target_word   <= '0;
                        r_guess_mode    <= 1'b1;
                        r_active_player <= 1'b0;
                        r_judge_req     <= 1'b0;
                        r_last_strike   <= '0;
                        r_last_ball     <= '0;
                        r_round_cnt     <= '0;
                        r_game_over     <= 1'b0;
                        r_winner        <= WIN_NONE;
                        r_p1_hit        <= 1'b0;
                    end
                end
                ST_SETUP_P1: begin
                    if (w_accept && w_ok) begin
                        r_secret_p1 <= w_next_word;
                        if (w_full) begin
                            r_state         <= ST_SETUP_P2;
                            r_active_player <= 1'b1;
                        end
                    end
                end
                ST_SETUP_P2: begin
                    if (w_accept && w_ok) begin
                        r_secret_p2 <= w_next_word;
                        if (w_full) begin
                            r_state         <= ST_TURN_P1;
                            r_active_player <= 1'b0;
                            r_round_cnt     <= 4'd1;
                            r_guess_word    <= '0;
                        end
                    end
                end
                ST_TURN_P1: begin
                    if (w_accept && w_ok) begin
                        r_guess_word <= w_next_word;
                        if (w_full) begin
                            r_state       <= ST_JUDGE_P1;
                            r_judge_req   <= 1'b1;
                            r_guess_mode  <= 1'b0;
                            r_target_word <= r_secret_p2;
                        end
                    end
                end
                ST_JUDGE_P1: begin
                    // P2 always gets its turn, so a P1 hit is only remembered here.
                    if (i_judge_ack) begin
                        r_last_strike   <= i_judge_strike;
                        r_last_ball     <= i_judge_ball;
                        r_p1_hit        <= (i_judge_strike == 2'(NUM_DIGITS));
                        r_state         <= ST_TURN_P2;
                        r_judge_req     <= 1'b0;
                        r_guess_mode    <= 1'b1;
                        r_active_player <= 1'b1;
                        r_guess_word    <= '0;
                    end
                end
                ST_TURN_P2: begin
                    if (w_accept && w_ok) begin
                        r_guess_word <= w_next_word;
                        if (w_full) begin
                            r_state       <= ST_JUDGE_P2;
                            r_judge_req   <= 1'b1;
                            r_guess_mode  <= 1'b0;
                            r_target_word <= r_secret_p1;
                        end
                    end
                end
                ST_JUDGE_P2: begin
                    if (i_judge_ack) begin
                        r_last_strike <= i_judge_strike;
                        r_last_ball   <= i_judge_ball;
                        r_judge_req   <= 1'b0;
                        if (r_p1_hit || w_p2_hit) begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                            r_winner    <= {w_p2_hit, r_p1_hit};
                        end else if (r_round_cnt == 4'(MAX_ROUNDS)) begin
                            r_state     <= ST_OVER;
                            r_game_over <= 1'b1;
                            r_winner    <= WIN_NONE;
                        end else begin
                            r_state         <= ST_TURN_P1;
                            r_round_cnt     <= r_round_cnt + 4'd1;
                            r_guess_mode    <= 1'b1;
                            r_active_player <= 1'b0;
                            r_guess_word    <= '0;
                            r_p1_hit        <= 1'b0;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_guess_mode    = r_guess_mode;
    assign o_active_player = r_active_player;
    assign o_digit_idx     = w_idx;
    assign o_secret_p1     = r_secret_p1;
    assign o_secret_p2     = r_secret_p2;
    assign o_guess_word    = r_guess_word;
    assign o_judge_req     = r_judge_req;
    assign o_target_word   = r_target_word;
    assign o_last_strike   = r_last_strike;
    assign o_last_ball     = r_last_ball;
    assign o_round_cnt     = r_round_cnt;
    assign o_invalid_entry = w_invalid;
    assign o_game_over     = r_game_over;
    assign o_winner        = r_winner;
    assign o_state         = r_state;

endmodule

// File: tb/tb_baseball_turn_ctrl.sv
// Self-checking bench for baseball_turn_ctrl: scripted games with a digit-entry model
// feeding an expected queue, plus judge handshake, win/draw/timeout and reset scenarios.
module tb_baseball_turn_ctrl;

    localparam int ND = 3;
    localparam int MR = 2;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_SETUP_P1 = 3'd1;
    localparam logic [2:0] S_SETUP_P2 = 3'd2;
    localparam logic [2:0] S_TURN_P1  = 3'd3;
    localparam logic [2:0] S_JUDGE_P1 = 3'd4;
    localparam logic [2:0] S_TURN_P2  = 3'd5;
    localparam logic [2:0] S_OVER     = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_start = 1'b0;
    logic [3:0]  i_digit_in = 4'd0;
    logic        i_enter_p1 = 1'b0;
    logic        i_enter_p2 = 1'b0;
    logic        i_judge_ack = 1'b0;
    logic [1:0]  i_judge_strike = 2'd0;
    logic [1:0]  i_judge_ball = 2'd0;
    logic        o_guess_mode;
    logic        o_active_player;
    logic [1:0]  o_digit_idx;
    logic [11:0] o_secret_p1;
    logic [11:0] o_secret_p2;
    logic [11:0] o_guess_word;
    logic        o_judge_req;
    logic [11:0] o_target_word;
    logic [1:0]  o_last_strike;
    logic [1:0]  o_last_ball;
    logic [3:0]  o_round_cnt;
    logic        o_invalid_entry;
    logic        o_game_over;
    logic [1:0]  o_winner;
    logic [2:0]  o_state;

    baseball_turn_ctrl #(
        .NUM_DIGITS (ND),
        .MAX_ROUNDS (MR)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .i_start         (i_start),
        .i_digit_in      (i_digit_in),
        .i_enter_p1      (i_enter_p1),
        .i_enter_p2      (i_enter_p2),
        .i_judge_ack     (i_judge_ack),
        .i_judge_strike  (i_judge_strike),
        .i_judge_ball    (i_judge_ball),
        .o_guess_mode    (o_guess_mode),
        .o_active_player (o_active_player),
        .o_digit_idx     (o_digit_idx),
        .o_secret_p1     (o_secret_p1),
        .o_secret_p2     (o_secret_p2),
        .o_guess_word    (o_guess_word),
        .o_judge_req     (o_judge_req),
        .o_target_word   (o_target_word),
        .o_last_strike   (o_last_strike),
        .o_last_ball     (o_last_ball),
        .o_round_cnt     (o_round_cnt),
        .o_invalid_entry (o_invalid_entry),
        .o_game_over     (o_game_over),
        .o_winner        (o_winner),
        .o_state         (o_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_inv  = 0;

    // Expected entry result: {invalid, idx[1:0], word[11:0]}
    logic [14:0] exp_q[$];
    logic [11:0] m_word = 12'h0;
    int          m_idx  = 0;

    // Driver: one enter pulse; the model predicts acceptance and pushes the expectation.
    task automatic press_chk(input logic en1, input logic en2, input logic [3:0] d,
                             input int sel, input logic act, input string name);
        logic        acc;
        logic        ok;
        logic [14:0] e;
        logic [11:0] obs_w;
        acc = act ? en2 : en1;
        ok  = (d <= 4'd9);
        for (int k = 0; k < m_idx; k++) begin
            if (m_word[k*4 +: 4] == d) ok = 1'b0;
        end
        if (acc && ok) begin
            m_word = {m_word[7:0], d};
            m_idx++;
        end
        e[14]    = acc && !ok;
        e[13:12] = (m_idx == ND) ? 2'd0 : 2'(m_idx);
        e[11:0]  = m_word;
        exp_q.push_back(e);
        if (m_idx == ND) begin
            m_word = 12'h0;
            m_idx  = 0;
        end
        i_digit_in = d;
        i_enter_p1 = en1;
        i_enter_p2 = en2;
        @(posedge clk); #1;
        i_enter_p1 = 1'b0;
        i_enter_p2 = 1'b0;
        e = exp_q.pop_front();
        obs_w = (sel == 0) ? o_secret_p1 : (sel == 1) ? o_secret_p2 : o_guess_word;
        n_inv += int'(o_invalid_entry);
        checks += 3;
        if (o_invalid_entry !== e[14]) begin
            errors++;
            $display("FAIL %s invalid got %b exp %b", name, o_invalid_entry, e[14]);
        end
        if (o_digit_idx !== e[13:12]) begin
            errors++;
            $display("FAIL %s idx got %0d exp %0d", name, o_digit_idx, e[13:12]);
        end
        if (obs_w !== e[11:0]) begin
            errors++;
            $display("FAIL %s word got %h exp %h", name, obs_w, e[11:0]);
        end
    endtask

    task automatic enter_word(input logic p2, input int sel, input logic [11:0] w, input string name);
        for (int i = 0; i < ND; i++) begin
            press_chk(!p2, p2, w[11-4*i -: 4], sel, p2, name);
        end
    endtask

    task automatic new_game();
        m_word  = 12'h0;
        m_idx   = 0;
        i_start = 1'b1;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    task automatic judge_step(input logic [11:0] eg, input logic [11:0] et,
                              input logic [1:0] s, input logic [1:0] b, input string name);
        int c;
        c = 0;
        while (!o_judge_req && c < 50) begin
            @(posedge clk); #1;
            c++;
        end
        checks += 3;
        if (o_judge_req !== 1'b1) begin
            errors++;
            $display("FAIL %s req_timeout got %b exp 1", name, o_judge_req);
        end
        if (o_guess_word !== eg) begin
            errors++;
            $display("FAIL %s guess got %h exp %h", name, o_guess_word, eg);
        end
        if (o_target_word !== et) begin
            errors++;
            $display("FAIL %s target got %h exp %h", name, o_target_word, et);
        end
        i_judge_ack    = 1'b1;
        i_judge_strike = s;
        i_judge_ball   = b;
        @(posedge clk); #1;
        i_judge_ack    = 1'b0;
        i_judge_strike = 2'd0;
        i_judge_ball   = 2'd0;
        checks += 2;
        if (o_judge_req !== 1'b0) begin
            errors++;
            $display("FAIL %s req_drop got %b exp 0", name, o_judge_req);
        end
        if ({o_last_strike, o_last_ball} !== {s, b}) begin
            errors++;
            $display("FAIL %s last got %b exp %b", name, {o_last_strike, o_last_ball}, {s, b});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({o_guess_mode, o_active_player, o_digit_idx, o_secret_p1, o_secret_p2, o_guess_word,
             o_judge_req, o_target_word, o_last_strike, o_last_ball, o_round_cnt,
             o_invalid_entry, o_game_over, o_winner, o_state} !== '0) begin
            errors++;
            $display("FAIL reset outputs not zero state %0d secret_p1 %h exp all 0", o_state, o_secret_p1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_setup();
        new_game();
        checks += 2;
        if (o_state !== S_SETUP_P1) begin
            errors++;
            $display("FAIL start_state got %0d exp %0d", o_state, S_SETUP_P1);
        end
        if (o_guess_mode !== 1'b1) begin
            errors++;
            $display("FAIL start_guess_mode got %b exp 1", o_guess_mode);
        end
        n_inv = 0;
        press_chk(1'b1, 1'b0, 4'd1,  0, 1'b0, "setup_d1");
        press_chk(1'b1, 1'b0, 4'd1,  0, 1'b0, "setup_dup");
        press_chk(1'b1, 1'b0, 4'd10, 0, 1'b0, "setup_range");
        press_chk(1'b1, 1'b0, 4'd2,  0, 1'b0, "setup_d2");
        press_chk(1'b1, 1'b0, 4'd3,  0, 1'b0, "setup_d3");
        checks += 3;
        if (n_inv != 2) begin
            errors++;
            $display("FAIL invalid_count got %0d exp 2", n_inv);
        end
        if (o_state !== S_SETUP_P2 || o_active_player !== 1'b1) begin
            errors++;
            $display("FAIL setup_p2_state got %0d/%b exp %0d/1", o_state, o_active_player, S_SETUP_P2);
        end
        if (o_secret_p1 !== 12'h123) begin
            errors++;
            $display("FAIL secret_p1 got %h exp 123", o_secret_p1);
        end
        enter_word(1'b1, 1, 12'h456, "setup_p2");
        checks += 3;
        if (o_secret_p2 !== 12'h456) begin
            errors++;
            $display("FAIL secret_p2 got %h exp 456", o_secret_p2);
        end
        if (o_state !== S_TURN_P1 || o_active_player !== 1'b0 || o_guess_mode !== 1'b1) begin
            errors++;
            $display("FAIL turn_p1_entry got %0d/%b/%b exp %0d/0/1", o_state, o_active_player, o_guess_mode, S_TURN_P1);
        end
        if (o_round_cnt !== 4'd1) begin
            errors++;
            $display("FAIL round_first got %0d exp 1", o_round_cnt);
        end
    endtask

    task automatic test_enter_select();
        press_chk(1'b0, 1'b1, 4'd5, 2, 1'b0, "p2_in_p1_turn");
        press_chk(1'b1, 1'b1, 4'd7, 2, 1'b0, "both_enter");
    endtask

    task automatic test_judge_hold();
        int bad;
        logic [11:0] g0;
        logic [11:0] t0;
        press_chk(1'b1, 1'b0, 4'd8, 2, 1'b0, "p1_guess_d2");
        press_chk(1'b1, 1'b0, 4'd9, 2, 1'b0, "p1_guess_d3");
        checks++;
        if (o_state !== S_JUDGE_P1 || o_judge_req !== 1'b1 || o_guess_mode !== 1'b0) begin
            errors++;
            $display("FAIL judge_entry got %0d/%b/%b exp %0d/1/0", o_state, o_judge_req, o_guess_mode, S_JUDGE_P1);
        end
        g0 = o_guess_word;
        t0 = o_target_word;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (o_judge_req !== 1'b1 || o_guess_word !== g0 || o_target_word !== t0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL judge_hold unstable cycles got %0d exp 0", bad);
        end
        judge_step(12'h789, 12'h456, 2'd3, 2'd0, "judge_p1_hit");
        checks++;
        if (o_state !== S_TURN_P2 || o_active_player !== 1'b1 || o_guess_word !== 12'h0) begin
            errors++;
            $display("FAIL turn_p2_entry got %0d/%b/%h exp %0d/1/000", o_state, o_active_player, o_guess_word, S_TURN_P2);
        end
    endtask

    task automatic test_p1_win();
        enter_word(1'b1, 2, 12'h124, "p2_guess");
        judge_step(12'h124, 12'h123, 2'd1, 2'd2, "judge_p2_miss");
        checks += 2;
        if (o_state !== S_OVER || o_game_over !== 1'b1 || o_guess_mode !== 1'b0) begin
            errors++;
            $display("FAIL p1_win_over got %0d/%b/%b exp %0d/1/0", o_state, o_game_over, o_guess_mode, S_OVER);
        end
        if (o_winner !== 2'b01) begin
            errors++;
            $display("FAIL p1_win_winner got %b exp 01", o_winner);
        end
        i_judge_ack    = 1'b1;
        i_judge_strike = 2'd0;
        i_judge_ball   = 2'd3;
        @(posedge clk); #1;
        i_judge_ack    = 1'b0;
        i_judge_ball   = 2'd0;
        checks++;
        if ({o_last_strike, o_last_ball} !== 4'b0110 || o_state !== S_OVER) begin
            errors++;
            $display("FAIL stray_ack got %b/%0d exp 0110/%0d", {o_last_strike, o_last_ball}, o_state, S_OVER);
        end
    endtask

    task automatic test_draw();
        new_game();
        checks++;
        if ({o_secret_p1, o_secret_p2, o_winner, o_game_over, o_round_cnt, o_last_strike} !== '0
            || o_state !== S_SETUP_P1) begin
            errors++;
            $display("FAIL restart_clear got %h/%b/%b/%0d exp 0 state %0d", o_secret_p1, o_winner, o_game_over, o_state, S_SETUP_P1);
        end
        enter_word(1'b0, 0, 12'h123, "draw_s1");
        enter_word(1'b1, 1, 12'h456, "draw_s2");
        enter_word(1'b0, 2, 12'h456, "draw_g1");
        judge_step(12'h456, 12'h456, 2'd3, 2'd0, "draw_j1");
        enter_word(1'b1, 2, 12'h123, "draw_g2");
        judge_step(12'h123, 12'h123, 2'd3, 2'd0, "draw_j2");
        checks++;
        if (o_state !== S_OVER || o_winner !== 2'b11 || o_game_over !== 1'b1) begin
            errors++;
            $display("FAIL draw got %0d/%b exp %0d/11", o_state, o_winner, S_OVER);
        end
    endtask

    task automatic test_timeout();
        new_game();
        enter_word(1'b0, 0, 12'h987, "to_s1");
        enter_word(1'b1, 1, 12'h012, "to_s2");
        for (int r = 1; r <= MR; r++) begin
            enter_word(1'b0, 2, 12'h345, "to_g1");
            judge_step(12'h345, 12'h012, 2'd0, 2'd1, "to_j1");
            enter_word(1'b1, 2, 12'h678, "to_g2");
            judge_step(12'h678, 12'h987, 2'd0, 2'd0, "to_j2");
            if (r < MR) begin
                checks++;
                if (o_state !== S_TURN_P1 || o_round_cnt !== 4'(r + 1) || o_game_over !== 1'b0) begin
                    errors++;
                    $display("FAIL next_round got %0d/%0d exp %0d/%0d", o_state, o_round_cnt, S_TURN_P1, r + 1);
                end
            end
        end
        checks++;
        if (o_state !== S_OVER || o_winner !== 2'b00 || o_round_cnt !== 4'(MR) || o_game_over !== 1'b1) begin
            errors++;
            $display("FAIL timeout got %0d/%b/%0d/%b exp %0d/00/%0d/1", o_state, o_winner, o_round_cnt, o_game_over, S_OVER, MR);
        end
    endtask

    task automatic test_reset_mid_judge();
        new_game();
        enter_word(1'b0, 0, 12'h135, "rst_s1");
        enter_word(1'b1, 1, 12'h246, "rst_s2");
        enter_word(1'b0, 2, 12'h247, "rst_g1");
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checks += 2;
        if ({o_guess_mode, o_active_player, o_digit_idx, o_secret_p1, o_secret_p2, o_guess_word,
             o_judge_req, o_target_word, o_last_strike, o_last_ball, o_round_cnt,
             o_invalid_entry, o_game_over, o_winner} !== '0) begin
            errors++;
            $display("FAIL async_rst outputs got req %b secret_p1 %h exp all 0", o_judge_req, o_secret_p1);
        end
        if (o_state !== S_IDLE) begin
            errors++;
            $display("FAIL async_rst state got %0d exp %0d", o_state, S_IDLE);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (o_state !== S_IDLE || o_judge_req !== 1'b0) begin
            errors++;
            $display("FAIL post_rst got %0d/%b exp %0d/0", o_state, o_judge_req, S_IDLE);
        end
    endtask

    initial begin
        test_reset();
        test_setup();
        test_enter_select();
        test_judge_hold();
        test_p1_win();
        test_draw();
        test_timeout();
        test_reset_mid_judge();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
